// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : opcodes, funct3 codes, exception causes and FSM encoding for the LSU
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] EXC_LD_MISALIGN = 2'd0;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL     = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT     = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_lane_align : store lane shift / byte enables and load lane extraction
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  lsu_size_e          st_size_i,
  input  logic [OFF_W-1:0]   st_off_i,
  input  logic [WIDTH-1:0]   st_data_i,
  output logic [WIDTH-1:0]   st_wdata_o,
  output logic [NB-1:0]      st_be_o,
  input  lsu_size_e          ld_size_i,
  input  logic               ld_signed_i,
  input  logic [OFF_W-1:0]   ld_off_i,
  input  logic [WIDTH-1:0]   ld_rdata_i,
  output logic [WIDTH-1:0]   ld_data_o
);

  logic [NB-1:0]    be_base;
  logic [WIDTH-1:0] ld_shift;
  logic [WIDTH-1:0] ld_keep;
  logic             ld_msb;

  always_comb begin
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
    case (st_size_i)
      SZ_BYTE: be_base = NB'(1);
      SZ_HALF: be_base = NB'(3);
      SZ_WORD: be_base = NB'(15);
      default: be_base = '1;
    endcase
    st_be_o = be_base << st_off_i;
  end

  // Bits above the access width are either cleared or filled with its MSB.
  always_comb begin
    ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SZ_BYTE: begin ld_keep = WIDTH'(8'hFF);         ld_msb = ld_shift[7];  end
      SZ_HALF: begin ld_keep = WIDTH'(16'hFFFF);      ld_msb = ld_shift[15]; end
      SZ_WORD: begin ld_keep = WIDTH'(32'hFFFF_FFFF); ld_msb = ld_shift[31]; end
      default: begin ld_keep = '1;                    ld_msb = 1'b0;         end
    endcase
    ld_data_o = (ld_shift & ld_keep) | ((ld_signed_i && ld_msb) ? ~ld_keep : '0);
  end

endmodule
`default_nettype wire

// File: rtl/lsu_req_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_req_ctrl : RV32/RV64 load/store decode and single-outstanding cache request
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [31:0]        instruction_i,
  input  logic [WIDTH-1:0]   rs1_data_i,
  input  logic [WIDTH-1:0]   rs2_data_i,
  output logic               req_read_o,
  output logic               req_write_o,
  output logic [WIDTH-1:0]   req_addr_o,
  output logic [WIDTH-1:0]   req_wdata_o,
  output logic [WIDTH/8-1:0] req_be_o,
  input  logic               req_ready_i,
  input  logic               resp_valid_i,
  input  logic [WIDTH-1:0]   resp_rdata_i,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [WIDTH-1:0]   wb_data_o,
  output logic               done_o,
  output logic               exc_valid_o,
  output logic [1:0]         exc_cause_o
);

  localparam int NB    = WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [TCNT_W-1:0] CNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [WIDTH-1:0]  addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [NB-1:0]     be_q, be_d;
  lsu_size_e         size_q, size_d;
  logic              sign_q, sign_d, store_q, store_d;
  logic [4:0]        rd_q, rd_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d, wb_valid_q, wb_valid_d, exc_valid_q, exc_valid_d;
  logic [1:0]        exc_cause_q, exc_cause_d;
  logic              ready_en_q;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load, is_store, instr_hs, f3_illegal, misaligned, timeout;
  logic [11:0]       imm12;
  logic [WIDTH-1:0]  ea, st_wdata, ld_data;
  logic [NB-1:0]     st_be;
  lsu_size_e         dec_size;
  logic              unused_rs1_field;

  assign unused_rs1_field = ^instruction_i[19:15];

  assign opcode   = instruction_i[6:0];
  assign funct3   = instruction_i[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign imm12    = is_store ? {instruction_i[31:25], instruction_i[11:7]} : instruction_i[31:20];
  assign ea       = rs1_data_i + {{(WIDTH-12){imm12[11]}}, imm12};
  assign dec_size = lsu_size_e'(funct3[1:0]);
  assign instr_hs = instr_valid_i && instr_ready_o;
  assign timeout  = (cnt_q == CNT_LAST);

  always_comb begin
    f3_illegal = 1'b1;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_illegal = 1'b0;
        F3_LD, F3_LWU:                       f3_illegal = (WIDTH == 32);
        default:                             f3_illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: f3_illegal = 1'b0;
        F3_SD:               f3_illegal = (WIDTH == 32);
        default:             f3_illegal = 1'b1;
      endcase
    end
    case (dec_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = ea[0];
      SZ_WORD: misaligned = |ea[1:0];
      default: misaligned = |ea[2:0];
    endcase
  end

  lsu_lane_align #(.WIDTH(WIDTH)) u_lane_align (
    .st_size_i   (dec_size),
    .st_off_i    (ea[OFF_W-1:0]),
    .st_data_i   (rs2_data_i),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_size_i   (size_q),
    .ld_signed_i (sign_q),
    .ld_off_i    (addr_q[OFF_W-1:0]),
    .ld_rdata_i  (resp_rdata_i),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_hs && (is_load || is_store) && !f3_illegal && !misaligned) state_d = ST_REQ;
      ST_REQ:  if (req_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (resp_valid_i || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ready_en_q holds instr_ready_o low until the first edge after reset release.
  always_comb begin
    instr_ready_o = ready_en_q && (state_q == ST_IDLE);
    req_read_o    = (state_q == ST_REQ) && !store_q;
    req_write_o   = (state_q == ST_REQ) && store_q;
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    size_d      = size_q;
    sign_d      = sign_q;
    store_d     = store_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    exc_cause_d = exc_cause_q;
    done_d      = 1'b0;
    wb_valid_d  = 1'b0;
    exc_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_hs && (is_load || is_store)) begin
          if (f3_illegal) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_ILLEGAL;
          end else if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_cause_d = is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          end else begin
            addr_d  = ea;
            size_d  = dec_size;
            sign_d  = ~funct3[2];
            store_d = is_store;
            rd_d    = instruction_i[11:7];
            wdata_d = st_wdata;
            be_d    = is_store ? st_be : '1;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TCNT_W'(1);
        // A response in the final counted cycle still beats the timeout.
        if (resp_valid_i) begin
          done_d     = 1'b1;
          wb_valid_d = ~store_q;
          if (!store_q) wb_data_d = ld_data;
        end else if (timeout) begin
          exc_valid_d = 1'b1;
          exc_cause_d = EXC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      size_q      <= SZ_BYTE;
      sign_q      <= 1'b0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      cnt_q       <= '0;
      wb_data_q   <= '0;
      exc_cause_q <= '0;
      done_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      exc_cause_q <= exc_cause_d;
      done_q      <= done_d;
      wb_valid_q  <= wb_valid_d;
      exc_valid_q <= exc_valid_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;
  assign req_be_o    = be_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = wb_data_q;
  assign done_o      = done_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_req_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_req_ctrl : randomized bench for a 32-bit and a 64-bit LSU instance
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lsu_req_ctrl;

  localparam int TMO0 = 8;
  localparam int TMO1 = 5;
  localparam int K_NONE = 0;
  localparam int K_EXC  = 1;
  localparam int K_MEM  = 2;

  typedef struct {
    int          kind;
    logic [1:0]  cause;
    logic        is_load;
    logic [4:0]  rd;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] wb;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  // index 0: WIDTH=32 instance, index 1: WIDTH=64 instance
  logic        instr_valid [2];
  logic [31:0] instruction [2];
  logic [63:0] rs1 [2];
  logic [63:0] rs2 [2];
  logic [63:0] rdata [2];
  logic        req_ready [2];
  logic        resp_valid [2];

  logic        instr_ready_w [2];
  logic        req_read_w [2];
  logic        req_write_w [2];
  logic [63:0] req_addr_w [2];
  logic [63:0] req_wdata_w [2];
  logic [7:0]  req_be_w [2];
  logic        wb_valid_w [2];
  logic [4:0]  wb_rd_w [2];
  logic [63:0] wb_data_w [2];
  logic        done_w [2];
  logic        exc_valid_w [2];
  logic [1:0]  exc_cause_w [2];

  logic [31:0] a32_addr, a32_wdata, a32_wb;
  logic [3:0]  a32_be;
  logic [63:0] a64_addr, a64_wdata, a64_wb;
  logic [7:0]  a64_be;

  assign req_addr_w[0]  = {32'b0, a32_addr};
  assign req_wdata_w[0] = {32'b0, a32_wdata};
  assign wb_data_w[0]   = {32'b0, a32_wb};
  assign req_be_w[0]    = {4'b0, a32_be};
  assign req_addr_w[1]  = a64_addr;
  assign req_wdata_w[1] = a64_wdata;
  assign wb_data_w[1]   = a64_wb;
  assign req_be_w[1]    = a64_be;

  lsu_req_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TMO0)) u_dut32 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .instr_valid_i(instr_valid[0]), .instr_ready_o(instr_ready_w[0]),
    .instruction_i(instruction[0]), .rs1_data_i(rs1[0][31:0]), .rs2_data_i(rs2[0][31:0]),
    .req_read_o(req_read_w[0]), .req_write_o(req_write_w[0]),
    .req_addr_o(a32_addr), .req_wdata_o(a32_wdata), .req_be_o(a32_be),
    .req_ready_i(req_ready[0]), .resp_valid_i(resp_valid[0]), .resp_rdata_i(rdata[0][31:0]),
    .wb_valid_o(wb_valid_w[0]), .wb_rd_o(wb_rd_w[0]), .wb_data_o(a32_wb),
    .done_o(done_w[0]), .exc_valid_o(exc_valid_w[0]), .exc_cause_o(exc_cause_w[0])
  );

  lsu_req_ctrl #(.WIDTH(64), .TIMEOUT_CYCLES(TMO1)) u_dut64 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .instr_valid_i(instr_valid[1]), .instr_ready_o(instr_ready_w[1]),
    .instruction_i(instruction[1]), .rs1_data_i(rs1[1]), .rs2_data_i(rs2[1]),
    .req_read_o(req_read_w[1]), .req_write_o(req_write_w[1]),
    .req_addr_o(a64_addr), .req_wdata_o(a64_wdata), .req_be_o(a64_be),
    .req_ready_i(req_ready[1]), .resp_valid_i(resp_valid[1]), .resp_rdata_i(rdata[1]),
    .wb_valid_o(wb_valid_w[1]), .wb_rd_o(wb_rd_w[1]), .wb_data_o(a64_wb),
    .done_o(done_w[1]), .exc_valid_o(exc_valid_w[1]), .exc_cause_o(exc_cause_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural reference: what a load/store should do, from the ISA rules.
  function automatic exp_t model(input int w, input logic [31:0] ins, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] rdat);
    exp_t e;
    logic [63:0] msk, imm, lmask, v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        illegal;
    int          nb, off;
    op = ins[6:0];
    f3 = ins[14:12];
    e.kind = K_NONE; e.cause = 2'd0; e.rd = ins[11:7]; e.addr = '0;
    e.wdata = '0; e.be = '0; e.wb = '0;
    e.is_load = (op == 7'b0000011);
    if (op != 7'b0000011 && op != 7'b0100011) return e;
    msk = (w == 32) ? 64'hFFFF_FFFF : '1;
    if (e.is_load) imm = {{52{ins[31]}}, ins[31:20]};
    else           imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    e.addr = (a + imm) & msk;
    nb = 1 << f3[1:0];
    if (e.is_load) illegal = (f3 == 3'd7) || (w == 32 && (f3 == 3'd3 || f3 == 3'd6));
    else           illegal = f3[2] || (w == 32 && f3 == 3'd3);
    if (illegal) begin
      e.kind = K_EXC; e.cause = 2'd2; return e;
    end
    if (e.addr % nb != 0) begin
      e.kind = K_EXC; e.cause = e.is_load ? 2'd0 : 2'd1; return e;
    end
    e.kind = K_MEM;
    off = int'(e.addr % (w / 8));
    if (!e.is_load) begin
      e.wdata = (b << (off * 8)) & msk;
      e.be    = 8'(((1 << nb) - 1) << off);
    end else begin
      e.be  = (w == 32) ? 8'h0F : 8'hFF;
      lmask = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
      v     = (rdat >> (off * 8)) & lmask;
      if (f3 < 3'd4 && v[nb*8-1]) v = v | ~lmask;
      e.wb  = v & msk;
    end
    return e;
  endfunction

  function automatic logic [31:0] mk_load(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_store(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic run_txn(input int d, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] rdat, input int rdy_dly, input int rsp_dly);
    exp_t e;
    int   w, tmo;
    w   = (d == 0) ? 32 : 64;
    tmo = (d == 0) ? TMO0 : TMO1;
    e   = model(w, ins, a, b, rdat);
    @(negedge sys_clk);
    check_eq("idle_ready", 64'(instr_ready_w[d]), 64'd1);
    check_eq("idle_pulses", 64'({done_w[d], wb_valid_w[d], exc_valid_w[d]}), 64'd0);
    instr_valid[d] = 1'b1; instruction[d] = ins; rs1[d] = a; rs2[d] = b;
    @(negedge sys_clk);
    instr_valid[d] = 1'b0;
    if (e.kind == K_NONE) begin
      check_eq("none_quiet", 64'({exc_valid_w[d], req_read_w[d], req_write_w[d], instr_ready_w[d]}), 64'b0001);
    end else if (e.kind == K_EXC) begin
      check_eq("exc_valid", 64'(exc_valid_w[d]), 64'd1);
      check_eq("exc_cause", 64'(exc_cause_w[d]), 64'(e.cause));
      check_eq("exc_no_req", 64'({req_read_w[d], req_write_w[d]}), 64'd0);
      check_eq("exc_ready", 64'(instr_ready_w[d]), 64'd1);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check_eq("req_rw", 64'({req_read_w[d], req_write_w[d]}), 64'({e.is_load, ~e.is_load}));
        check_eq("req_addr", req_addr_w[d], e.addr);
        check_eq("req_be", 64'(req_be_w[d]), 64'(e.be));
        if (!e.is_load) check_eq("req_wdata", req_wdata_w[d], e.wdata);
        check_eq("req_not_ready", 64'(instr_ready_w[d]), 64'd0);
        if (i < rdy_dly) begin
          resp_valid[d] = 1'($urandom_range(0, 1));
          @(negedge sys_clk);
          resp_valid[d] = 1'b0;
        end
      end
      req_ready[d] = 1'b1;
      @(negedge sys_clk);
      req_ready[d] = 1'b0;
      check_eq("wait_rw", 64'({req_read_w[d], req_write_w[d]}), 64'd0);
      check_eq("wait_addr", req_addr_w[d], e.addr);
      for (int i = 0; i <= tmo; i++) begin
        if (i == rsp_dly) begin
          resp_valid[d] = 1'b1; rdata[d] = rdat;
          @(negedge sys_clk);
          resp_valid[d] = 1'b0;
          check_eq("done", 64'(done_w[d]), 64'd1);
          check_eq("wb_valid", 64'(wb_valid_w[d]), 64'(e.is_load));
          check_eq("no_exc", 64'(exc_valid_w[d]), 64'd0);
          if (e.is_load) begin
            check_eq("wb_data", wb_data_w[d], e.wb);
            check_eq("wb_rd", 64'(wb_rd_w[d]), 64'(e.rd));
          end
          break;
        end
        if (i == tmo) begin
          check_eq("tmo_exc", 64'(exc_valid_w[d]), 64'd1);
          check_eq("tmo_cause", 64'(exc_cause_w[d]), 64'd3);
          check_eq("tmo_no_done", 64'({done_w[d], wb_valid_w[d]}), 64'd0);
          resp_valid[d] = 1'b1; rdata[d] = rdat;
          @(negedge sys_clk);
          resp_valid[d] = 1'b0;
          check_eq("late_resp_drop", 64'({done_w[d], wb_valid_w[d], exc_valid_w[d]}), 64'd0);
          break;
        end
        check_eq("wait_quiet", 64'({done_w[d], exc_valid_w[d]}), 64'd0);
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic rand_txn(input int d);
    logic [31:0] ins;
    logic [63:0] a, b, rdat;
    logic [11:0] imm;
    logic [2:0]  f3;
    int          sel, tmo, rsp;
    tmo  = (d == 0) ? TMO0 : TMO1;
    sel  = $urandom_range(0, 9);
    f3   = 3'($urandom_range(0, 7));
    imm  = 12'($urandom);
    a    = {32'($urandom), 32'($urandom)};
    b    = {32'($urandom), 32'($urandom)};
    rdat = {32'($urandom), 32'($urandom)};
    if (d == 0) begin a[63:32] = '0; b[63:32] = '0; rdat[63:32] = '0; end
    if ($urandom_range(0, 9) < 7) begin
      imm[2:0] = 3'b000;
      a[2:0]   = 3'(($urandom_range(0, 7) >> f3[1:0]) << f3[1:0]);
    end
    if (sel < 5) ins = mk_load(imm, f3, 5'($urandom));
    else if (sel < 9) begin
      if ($urandom_range(0, 3) != 0) f3[2] = 1'b0;
      ins = mk_store(imm, f3);
    end else ins = {25'($urandom), 7'b0110011};
    rsp = ($urandom_range(0, 7) == 0) ? tmo + 2 : int'($urandom_range(0, tmo - 1));
    run_txn(d, ins, a, b, rdat, int'($urandom_range(0, 3)), rsp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      instr_valid[d] = 1'b0; instruction[d] = '0; rs1[d] = '0; rs2[d] = '0;
      rdata[d] = '0; req_ready[d] = 1'b0; resp_valid[d] = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", 64'(instr_ready_w[d]), 64'd0);
      check_eq("rst_req", 64'({req_read_w[d], req_write_w[d]}), 64'd0);
      check_eq("rst_addr", req_addr_w[d], 64'd0);
      check_eq("rst_be_wdata", req_wdata_w[d] | 64'(req_be_w[d]), 64'd0);
      check_eq("rst_pulses", 64'({done_w[d], wb_valid_w[d], exc_valid_w[d], exc_cause_w[d]}), 64'd0);
    end
    sys_rst = 1'b0;
    #1;
    check_eq("rst_rel_ready_low", 64'(instr_ready_w[0]), 64'd0);
    @(negedge sys_clk);
    check_eq("rst_rel_ready", 64'({instr_ready_w[0], instr_ready_w[1]}), 64'b11);

    run_txn(0, mk_load(12'd3, 3'b000, 5'd5), 64'h100, 64'h0, 64'h80FF1234, 0, 1);      // LB
    run_txn(0, mk_store(12'd2, 3'b001), 64'h100, 64'h0000ABCD, 64'h0, 1, 0);            // SH
    run_txn(0, mk_load(12'd0, 3'b010, 5'd7), 64'h101, 64'h0, 64'h0, 0, 0);              // LW misaligned
    run_txn(0, mk_load(12'd0, 3'b010, 5'd7), 64'h40, 64'h0, 64'hDEADBEEF, 3, 2);        // backpressure
    run_txn(0, mk_store(12'h7FC, 3'b010), 64'h200, 64'h12345678, 64'h0, 0, TMO0 + 2);   // timeout
    run_txn(0, mk_load(12'd2, 3'b001, 5'd0), 64'h100, 64'h0, 64'hF00D8001, 0, TMO0 - 1); // LH rd=0, last cycle
    run_txn(1, mk_load(12'd0, 3'b110, 5'd9), 64'h204, 64'h0, 64'h89ABCDEF_00000000, 0, 0); // LWU 64
    run_txn(0, mk_load(12'd0, 3'b110, 5'd9), 64'h204, 64'h0, 64'h0, 0, 0);              // LWU 32
    run_txn(1, mk_store(12'd8, 3'b011), 64'h1000, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1);  // SD
    run_txn(1, mk_load(12'hFF8, 3'b011, 5'd3), 64'h1010, 64'h0, 64'h8000_0000_0000_0001, 0, TMO1 + 2);
    run_txn(1, mk_store(12'd1, 3'b001), 64'h100, 64'h0, 64'h0, 0, 0);                   // SH misaligned

    for (int k = 0; k < 150; k++) begin
      rand_txn(0);
      rand_txn(1);
    end

    // Reset in the middle of a request must abort without any pulse.
    @(negedge sys_clk);
    instr_valid[0] = 1'b1; instruction[0] = mk_load(12'd0, 3'b010, 5'd4); rs1[0] = 64'h40;
    @(negedge sys_clk);
    instr_valid[0] = 1'b0;
    check_eq("mr_req", 64'(req_read_w[0]), 64'd1);
    sys_rst = 1'b1;
    resp_valid[0] = 1'b1;
    #1;
    check_eq("mr_async", 64'({req_read_w[0], instr_ready_w[0]}), 64'd0);
    repeat (2) begin
      @(negedge sys_clk);
      check_eq("mr_quiet", 64'({done_w[0], wb_valid_w[0], exc_valid_w[0]}), 64'd0);
    end
    resp_valid[0] = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_eq("mr_ready", 64'(instr_ready_w[0]), 64'd1);
    repeat (3) begin
      @(negedge sys_clk);
      check_eq("mr_after", 64'({done_w[0], wb_valid_w[0], exc_valid_w[0], req_read_w[0]}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_req_ctrl.md
Name: lsu_req_ctrl

Overview:
Parametrised load/store unit placed between the core's decode stage and the L1 data cache controller of the MESI system. It decodes RV32/RV64 LOAD/STORE instructions and computes effective address = rs1 + sign-extended imm. It issues one outstanding cache request at a time, using a valid/ready request handshake and a response strobe. Beyond a plain request generator, it adds byte-enable lane steering, misalignment and illegal-funct3 exceptions, a response timeout, and a writeback port.

Parameters:
WIDTH, 32, data/address width; legal values 32 or 64 (64 enables LD/SD/LWU).
TIMEOUT_CYCLES, 256, cycles in WAIT without resp_valid_i before timeout exception; must be >= 1.
TCNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-high
instr_valid_i  in  1  instruction valid
instr_ready_o  out  1  LSU can accept an instruction (high only in IDLE)
instruction_i  in  32  RISC-V instruction word
rs1_data_i  in  WIDTH  base register value
rs2_data_i  in  WIDTH  store source value
req_read_o  out  1  cache read request
req_write_o  out  1  cache write request
req_addr_o  out  WIDTH  byte address, unmodified effective address
req_wdata_o  out  WIDTH  store data shifted into its byte lane
req_be_o  out  WIDTH/8  byte enables, all-ones for loads
req_ready_i  in  1  cache accepts request this cycle
resp_valid_i  in  1  cache response strobe, 1 cycle
resp_rdata_i  in  WIDTH  naturally aligned WIDTH-bit word containing the access
wb_valid_o  out  1  1-cycle load writeback pulse
wb_rd_o  out  5  destination register
wb_data_o  out  WIDTH  extended load result
done_o  out  1  1-cycle pulse on completion of any load or store
exc_valid_o  out  1  1-cycle exception pulse
exc_cause_o  out  2  0 misaligned load, 1 misaligned store, 2 illegal funct3, 3 timeout

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. instr_ready_o rises on the first clock after reset deassertion. Reset mid-transaction aborts silently, with no done_o or exc_valid_o.
- FSM states: IDLE, REQ, WAIT.
- IDLE, handshake at cycle N (instr_valid_i & instr_ready_o):
  - Opcode other than LOAD/STORE: consumed, no action.
  - Illegal funct3 (LD/LWU/SD when WIDTH=32, or reserved code): exc_valid_o at N+1, cause 2, stay IDLE.
  - Misaligned access (half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0): exc_valid_o at N+1, cause 0 or 1, no request issued, stay IDLE.
  - Otherwise: latch addr, size, sign flag, rd, wdata, be; enter REQ. req_*_o are valid from N+1.
- REQ: request outputs held stable until req_ready_i is sampled high, then enter WAIT and drop req_read_o/req_write_o on the next edge. req_addr_o, req_wdata_o and req_be_o hold their values. resp_valid_i in REQ is ignored.
- WAIT: counter increments each cycle.
  - resp_valid_i at cycle M: done_o at M+1. Loads also assert wb_valid_o at M+1 with lane-extracted, sign- or zero-extended data. Return to IDLE.
  - Counter reaching TIMEOUT_CYCLES with no response: exc_valid_o with cause 3, return to IDLE.
  - resp_valid_i and the timeout in the same cycle: response wins.
- resp_valid_i in IDLE (late response after timeout) is dropped.
- Load lane offset = addr[log2(WIDTH/8)-1:0]. Extract byte/half/word at offset × 8. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- Store: wdata = rs2 << (offset × 8). be = (1<<bytes)-1 << offset.
- wb_valid_o is still pulsed when rd = 0; suppression is the register file's responsibility.

Decomposition:
- Package lsu_pkg: opcode constants (LOAD 7'b0000011, STORE 7'b0100011), funct3 codes (LB..LWU, SB..SD), exc_cause encodings, FSM state encoding.
- Sub-module lsu_lane_align (combinational): store lane shift and byte-enable generation, plus load lane extraction and extension.

Test Plan:
- LB: rs1=0x100, imm=3, resp_rdata=0x80FF1234 -> req_addr 0x103, be 4'hF; wb_data 0xFFFFFF80 and wb_valid one cycle after the response.
- SH: rs1=0x100, imm=2, rs2=0x0000ABCD -> req_wdata 0xABCD0000, req_be 4'b1100, req_write_o=1; done_o pulse, no wb_valid.
- LW: rs1=0x101, imm=0 -> exc_valid with cause 0 at N+1; req_read_o never asserts; instr_ready_o stays 1.
- Backpressure: req_ready_i low for 3 cycles -> req_addr, wdata and be stable for all 4 request cycles; instr_ready_o low throughout.
- Timeout: TIMEOUT_CYCLES=8, no response -> exc cause 3 eight cycles into WAIT; a late resp_valid_i afterwards gives no wb_valid and no done.
- WIDTH=64 LWU: rs1=0x204, resp_rdata=0x89ABCDEF_00000000 -> wb_data 0x0000000089ABCDEF. The same LWU with WIDTH=32 -> exc cause 2.
